// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor
// Decodes the Q bus of a WIDTH-stage Johnson counter into a registered
// one-hot phase and binary index, checks that the code advances one legal
// step at a time, counts full revolutions and latches a sticky error on
// illegal or skipped codes.
//
// Ports:
//   clk        rising-edge clock (same as the Johnson counter)
//   rst        synchronous active-high reset
//   en         sample qualifier; q_in is evaluated only when en=1
//   q_in       Johnson code from the counter
//   phase      one-hot decoded phase (registered)
//   phase_idx  binary phase index (registered)
//   valid      high while locked
//   wrap       one-cycle pulse on a locked step from the last index to 0
//   cycle_cnt  number of wraps since reset, modulo 2^CYC_W
//   err        sticky error flag
//   err_code   q_in value that first caused an error
//
// Optional feature: define JOHNSON_PHASE_MON_AUTORECOVER_EN to let FAULT
// return to ACQUIRE when code 0 is sampled (err/err_code remain sticky).

module johnson_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int CYC_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              q_in,
    output logic [2*WIDTH-1:0]            phase,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          valid,
    output logic                          wrap,
    output logic [CYC_W-1:0]              cycle_cnt,
    output logic                          err,
    output logic [WIDTH-1:0]              err_code
);

    localparam int unsigned NPH   = 2 * WIDTH;
    localparam int unsigned IDX_W = $clog2(NPH);
    localparam int unsigned CNT_W = $clog2(NPH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   step_cnt, step_cnt_n;
    logic [NPH-1:0]     phase_n;
    logic [IDX_W-1:0]   idx_n;
    logic               valid_n, wrap_n, err_n;
    logic [CYC_W-1:0]   cyc_n;
    logic [WIDTH-1:0]   err_code_n;

    // Legal code for index k: k<WIDTH -> low k bits set;
    // k>=WIDTH -> low (k-WIDTH) bits clear, rest set.
    function automatic logic [WIDTH-1:0] code_of(input int unsigned k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k < WIDTH) return ~(ones << k);
        else           return ones << (k - WIDTH);
    endfunction

    logic             code_legal;
    logic [IDX_W-1:0] code_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_next, is_hold;

    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int unsigned k = 0; k < NPH; k++) begin
            if (q_in == code_of(k)) begin
                code_legal = 1'b1;
                code_idx   = k[IDX_W-1:0];
            end
        end
    end

    // phase_idx always equals the previously accepted index outside FAULT,
    // so it doubles as prev_idx for the step checks.
    assign succ_idx = (phase_idx == IDX_W'(NPH - 1)) ? '0 : phase_idx + IDX_W'(1);
    assign is_next  = code_legal && (code_idx == succ_idx);
    assign is_hold  = code_legal && (code_idx == phase_idx);

    always_comb begin
        logic fault_entry;
        logic track;
        fault_entry = 1'b0;
        track       = 1'b0;
        state_n     = state;
        step_cnt_n  = step_cnt;
        phase_n     = phase;
        idx_n       = phase_idx;
        valid_n     = valid;
        wrap_n      = 1'b0;
        cyc_n       = cycle_cnt;
        err_n       = err;
        err_code_n  = err_code;

        if (en) begin
            case (state)
                IDLE: begin
                    if (code_legal) begin
                        state_n    = ACQUIRE;
                        step_cnt_n = '0;
                        track      = 1'b1;
                    end else begin
                        fault_entry = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!code_legal) begin
                        fault_entry = 1'b1;
                    end else if (is_next) begin
                        track      = 1'b1;
                        step_cnt_n = step_cnt + CNT_W'(1);
                        if (step_cnt + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
                            state_n = LOCKED;
                            valid_n = 1'b1;
                        end
                    end else if (!is_hold) begin
                        track      = 1'b1;
                        step_cnt_n = '0;
                    end
                end
                LOCKED: begin
                    if (!code_legal) begin
                        fault_entry = 1'b1;
                    end else if (is_next) begin
                        track = 1'b1;
                        if (phase_idx == IDX_W'(NPH - 1)) begin
                            wrap_n = 1'b1;
                            cyc_n  = cycle_cnt + CYC_W'(1);
                        end
                    end else if (is_hold) begin
                        // no change
                    end else if (code_idx == '0) begin
                        // upstream counter restarted: reacquire without error
                        state_n    = ACQUIRE;
                        valid_n    = 1'b0;
                        step_cnt_n = '0;
                        track      = 1'b1;
                    end else begin
                        fault_entry = 1'b1;
                    end
                end
                FAULT: begin
`ifdef JOHNSON_PHASE_MON_AUTORECOVER_EN
                    if (code_legal && code_idx == '0) begin
                        state_n    = ACQUIRE;
                        step_cnt_n = '0;
                        track      = 1'b1;
                    end
`endif
                end
                default: state_n = IDLE;
            endcase
        end

        if (track) begin
            idx_n   = code_idx;
            phase_n = NPH'(1) << code_idx;
        end

        // phase_idx deliberately keeps its last value on fault entry
        if (fault_entry) begin
            state_n = FAULT;
            phase_n = '0;
            valid_n = 1'b0;
            err_n   = 1'b1;
            if (!err) err_code_n = q_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step_cnt  <= '0;
            phase     <= '0;
            phase_idx <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            cycle_cnt <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_n;
            step_cnt  <= step_cnt_n;
            phase     <= phase_n;
            phase_idx <= idx_n;
            valid     <= valid_n;
            wrap      <= wrap_n;
            cycle_cnt <= cyc_n;
            err       <= err_n;
            err_code  <= err_code_n;
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor
// Directed self-checking bench for johnson_phase_monitor (WIDTH=4,
// CYC_W=8, LOCK_CNT=2). Each step pushes its expected outputs to a
// scoreboard queue, drives the inputs, and pops/compares one clock later.
// Expected values follow JOHNSON_PHASE_MON_AUTORECOVER_EN when defined.

module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] q_in = '0;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       valid;
    logic       wrap;
    logic [7:0] cycle_cnt;
    logic       err;
    logic [3:0] err_code;

    johnson_phase_monitor #(
        .WIDTH   (4),
        .CYC_W   (8),
        .LOCK_CNT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .q_in     (q_in),
        .phase    (phase),
        .phase_idx(phase_idx),
        .valid    (valid),
        .wrap     (wrap),
        .cycle_cnt(cycle_cnt),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ph;
        logic [2:0] ix;
        logic       v;
        logic       w;
        logic [7:0] cc;
        logic       er;
        logic [3:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [3:0] codes [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s at vector %0d: got %h expected %h", tag, vectors, obs, expv);
        end
    endtask

    // Drive one sample, then compare all outputs against the popped expectation.
    task automatic step(input logic r, input logic e, input logic [3:0] q,
                        input logic [7:0] ph, input logic [2:0] ix, input logic v,
                        input logic w, input logic [7:0] cc, input logic er,
                        input logic [3:0] ec);
        exp_t x;
        exp_t got;
        x.ph = ph; x.ix = ix; x.v = v; x.w = w; x.cc = cc; x.er = er; x.ec = ec;
        exp_q.push_back(x);
        @(negedge clk);
        rst  = r;
        en   = e;
        q_in = q;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        vectors++;
        chk("phase",     32'(phase),     32'(got.ph));
        chk("phase_idx", 32'(phase_idx), 32'(got.ix));
        chk("valid",     32'(valid),     32'(got.v));
        chk("wrap",      32'(wrap),      32'(got.w));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(got.cc));
        chk("err",       32'(err),       32'(got.er));
        chk("err_code",  32'(err_code),  32'(got.ec));
    endtask

    initial begin
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
        codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;

        // reset lock-in and full revolution
        step(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 4'h0);
        step(1, 1, 4'b0101, 8'h00, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0111, 8'h08, 3, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b1111, 8'h10, 4, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b1110, 8'h20, 5, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b1100, 8'h40, 6, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b1000, 8'h80, 7, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0000, 8'h01, 0, 1, 1, 1, 0, 4'h0);
        step(0, 1, 4'b0001, 8'h02, 1, 1, 0, 1, 0, 4'h0);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 1, 0, 4'h0);
        step(0, 1, 4'b0111, 8'h08, 3, 1, 0, 1, 0, 4'h0);

        // hold: en low with garbage on q_in, then a repeated code
        step(0, 0, 4'b0101, 8'h08, 3, 1, 0, 1, 0, 4'h0);
        step(0, 0, 4'b1000, 8'h08, 3, 1, 0, 1, 0, 4'h0);
        step(0, 0, 4'b0000, 8'h08, 3, 1, 0, 1, 0, 4'h0);
        step(0, 1, 4'b0111, 8'h08, 3, 1, 0, 1, 0, 4'h0);

        // upstream restart from idx 5, then relock
        step(0, 1, 4'b1111, 8'h10, 4, 1, 0, 1, 0, 4'h0);
        step(0, 1, 4'b1110, 8'h20, 5, 1, 0, 1, 0, 4'h0);
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 1, 0, 4'h0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 1, 0, 4'h0);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 1, 0, 4'h0);

        // illegal code while locked at idx 2; first error wins
        step(0, 1, 4'b0101, 8'h00, 2, 0, 0, 1, 1, 4'b0101);
        step(0, 1, 4'b1100, 8'h00, 2, 0, 0, 1, 1, 4'b0101);

        // code 0 in FAULT
`ifdef JOHNSON_PHASE_MON_AUTORECOVER_EN
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 1, 1, 4'b0101);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 1, 1, 4'b0101);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 1, 1, 4'b0101);
`else
        step(0, 1, 4'b0000, 8'h00, 2, 0, 0, 1, 1, 4'b0101);
        step(0, 1, 4'b0001, 8'h00, 2, 0, 0, 1, 1, 4'b0101);
        step(0, 1, 4'b0011, 8'h00, 2, 0, 0, 1, 1, 4'b0101);
`endif

        // reset from a sticky-error state
        step(1, 1, 4'b0011, 8'h00, 0, 0, 0, 0, 0, 4'h0);

        // skip while locked at idx 2
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 0, 0, 4'h0);
        step(0, 1, 4'b1111, 8'h00, 2, 0, 0, 0, 1, 4'b1111);

        // illegal code straight out of IDLE
        step(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b1010, 8'h00, 0, 0, 0, 0, 1, 4'b1010);

        // reset while locked, then 256 revolutions to roll cycle_cnt over
        step(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 0, 0, 4'h0);
        step(1, 1, 4'b0111, 8'h00, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 0, 0, 4'h0);
        step(0, 1, 4'b0011, 8'h04, 2, 1, 0, 0, 0, 4'h0);
        begin
            int unsigned wraps = 0;
            for (int unsigned n = 3; n < 3 + 8 * 256; n++) begin
                int unsigned k;
                logic [2:0] kx;
                k  = n % 8;
                kx = k[2:0];
                if (k == 0) wraps++;
                step(0, 1, codes[k], 8'h01 << kx, kx, 1, (k == 0),
                     wraps[7:0], 0, 4'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the 4-stage Johnson counter and consumes its Q bus.
- Decodes the thermometer-style Johnson code into a registered one-hot phase and a binary phase index.
- Checks step-by-step sequence legality, counts full revolutions, and flags illegal or skipped codes with a sticky error.
- Downstream logic uses phase/valid as a clean 2*WIDTH-phase timing source.

Parameters:
WIDTH, 4, number of Johnson stages; 2*WIDTH legal codes/phases
CYC_W, 8, width of revolution counter
LOCK_CNT, 2, consecutive legal +1 steps required to declare lock (1..2*WIDTH)

Ports:
clk  input  1  rising-edge clock, same clock as the Johnson counter
rst  input  1  synchronous active-high reset
en  input  1  sample qualifier; q_in is evaluated only on cycles with en=1 (tie high when the counter advances every clock)
q_in  input  WIDTH  Johnson code from counter Q outputs
phase  output  2*WIDTH  one-hot decoded phase, registered
phase_idx  output  $clog2(2*WIDTH)  binary phase index, registered
valid  output  1  high while in LOCKED
wrap  output  1  one-cycle pulse on a locked step from index 2*WIDTH-1 to 0
cycle_cnt  output  CYC_W  number of wraps since reset, modulo 2^CYC_W
err  output  1  sticky error flag
err_code  output  WIDTH  q_in value that first caused an error

Behaviour:
- Code map, index k:
  - 0 <= k < WIDTH: low k bits are 1, the rest are 0.
  - WIDTH <= k < 2*WIDTH: low (k-WIDTH) bits are 0, the rest are 1.
  - For WIDTH=4: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
  - Any other pattern is illegal.
- "next" means idx == (prev_idx+1) mod 2*WIDTH. "hold" means idx == prev_idx.
- Reset, on rst=1 at a clock edge:
  - state=IDLE, phase=0, phase_idx=0, valid=0, wrap=0, cycle_cnt=0, err=0, err_code=0, step count=0.
  - rst overrides all other inputs, including mid-operation.
- Latency: all outputs are registered and update on the edge that samples en=1. Outputs are visible the following cycle. With en=0, every output holds its value, except wrap, which is 0.
- IDLE:
  - Legal code → ACQUIRE, prev_idx=idx, step count=0.
  - Illegal code → FAULT.
- ACQUIRE:
  - next → step count +1; when it reaches LOCK_CNT → LOCKED.
  - hold → no change.
  - Other legal code → prev_idx=idx, step count=0, stay in ACQUIRE.
  - Illegal code → FAULT.
- LOCKED:
  - next → stay; wrap=1 and cycle_cnt+1 when prev_idx==2*WIDTH-1. cycle_cnt wraps from all-ones to 0.
  - hold → stay.
  - Code 0 when not a next step (upstream counter reset) → ACQUIRE, step count=0, no error.
  - Any other legal code (skip) → FAULT.
  - Illegal code → FAULT.
- FAULT entry:
  - err=1.
  - err_code captures the offending q_in only if err was 0; the first error wins.
  - phase=0 and valid=0. phase_idx holds its last value.
- phase and phase_idx:
  - In IDLE, ACQUIRE and LOCKED, they track every legal sampled code.
  - In FAULT, phase stays 0.
- wrap is never asserted outside LOCKED.

Optional Feature:
- Macro: JOHNSON_PHASE_MON_AUTORECOVER_EN.
- Defined: in FAULT, a sampled code 0 → ACQUIRE with step count=0 and phase tracking resumed. err and err_code stay sticky until rst.
- Undefined: FAULT is left only by rst; q_in is ignored in FAULT.

Test Plan:
- Reset lock-in: rst high 2 cycles, then en=1 and q_in = 0000,0001,0011,…,1000,0000 → valid=1 after the 3rd sample (LOCK_CNT=2). wrap pulses exactly once, on the cycle after sampling the 0000 that follows 1000. cycle_cnt=1. phase walks 00000001→10000000→00000001.
- Hold: locked at idx 3, en=0 for 3 cycles, then q_in=0111 with en=1 → all outputs unchanged, wrap=0, valid=1, err=0.
- Illegal code: locked at idx 2, q_in=0101 → next cycle err=1, err_code=0101, phase=0, valid=0. A later q_in=1100 does not change err_code.
- Skip: locked at idx 2 (0011), q_in=1111 → FAULT, err=1, err_code=1111.
- Upstream restart: locked at idx 5 (1110), q_in=0000 → ACQUIRE, valid=0, err=0, phase_idx=0. Relocks after 0001,0011.
- Feature and mid-op reset: in FAULT, q_in=0000 → with the macro, ACQUIRE and relock while err stays 1; without it, remain in FAULT. rst=1 in any state → all outputs 0 on the next cycle.
